led_switch_io: RTL and testbench
================================

LED_SWITCH_IO -- requirements
Module: led_switch_io

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20000, the number of consecutive cycles a synchronised input must differ from its stable value before it is accepted.
REQ-002 The block SHALL have parameter LED_ADDR, default 32'hFFFFFC60, the LED register address (read/write).
REQ-003 The block SHALL have parameter SW_ADDR, default 32'hFFFFFC70, the debounced switch value address (read-only).
REQ-004 The block SHALL have parameter STAT_ADDR, default 32'hFFFFFC74, the status address (bit0 = button press pending; read-clear).
REQ-005 The block SHALL have port clock, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-007 The block SHALL have port io_read, input, 1 bit, the IO read strobe from the controller.
REQ-008 The block SHALL have port io_write, input, 1 bit, the IO write strobe from the controller.
REQ-009 The block SHALL have port addr, input, 32 bits, the IO address (ALU result).
REQ-010 The block SHALL have port wdata, input, 32 bits, the register data to write to IO.
REQ-011 The block SHALL have port io_rdata, output, 24 bits, the IO read data returned to the memory/IO mux.
REQ-012 The block SHALL have port sw_in, input, 24 bits, the raw asynchronous board switches.
REQ-013 The block SHALL have port btn_in, input, 1 bit, the raw asynchronous confirm button, active-high.
REQ-014 The block SHALL have port led_out, output, 24 bits, the LED drive, active-high, registered.

Function
REQ-015 Address decode SHALL be a full 32-bit equality compare; hits are qualified by io_read or io_write only.
REQ-016 On a rising edge with io_write=1 and addr=LED_ADDR, the LED register SHALL load wdata[23:0]; wdata[31:24] is ignored.
REQ-017 led_out SHALL equal the LED register; a write is visible on led_out one cycle after the write edge.
REQ-018 io_write to SW_ADDR, STAT_ADDR or any unmapped address SHALL change no state.
REQ-019 io_rdata SHALL be combinational from registered state: LED register at LED_ADDR; debounced switches at SW_ADDR; {23'b0, pending} at STAT_ADDR; 24'h0 for unmapped addresses or io_read=0.
REQ-020 sw_in and btn_in SHALL each pass through a 2-flop synchroniser before any other use.
REQ-021 Switch debounce SHALL use one shared counter: synced==stable -> counter cleared; else counter increments, and when it equals DEBOUNCE_CYCLES-1, stable loads synced and the counter clears.
REQ-022 A raw switch change held steady SHALL appear at SW_ADDR exactly DEBOUNCE_CYCLES+2 rising edges after it is presented.
REQ-023 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL never reach the stable value; the counter restarts from 0 on any return to stable.
REQ-024 The button SHALL be debounced by an independent counter under the same rule as REQ-021.
REQ-025 A debounced button 0->1 transition SHALL set pending; 1->0 SHALL have no effect.
REQ-026 A rising edge with io_read=1 and addr=STAT_ADDR SHALL clear pending; the read returns the pre-clear value.
REQ-027 If a press event and a status read-clear occur on the same edge, pending SHALL end at 1.
REQ-028 If io_read and io_write are both high, the write SHALL take effect and io_rdata SHALL return the pre-write value.
REQ-029 Counters SHALL be sized ceil(log2(DEBOUNCE_CYCLES))+1 bits and SHALL never wrap.

Reset
REQ-030 reset_n=0 SHALL immediately force LED register, led_out, synchroniser flops, stable switch/button values, counters and pending to 0, independent of clock.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count; after release, debounce restarts from count 0 against stable=0.
REQ-032 The first rising edge after reset_n deasserts SHALL behave as a normal cycle.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-033 A directed scenario SHALL cover: write wdata=32'hAB123456 to LED_ADDR -> led_out=24'h123456 next cycle; read LED_ADDR -> io_rdata=24'h123456.
REQ-034 A directed scenario SHALL cover: sw_in 0->24'h00F00F held -> SW_ADDR reads 0 for 5 edges and 24'h00F00F from edge 6 on.
REQ-035 A directed scenario SHALL cover: sw_in pulse of 24'hFFFFFF for 3 cycles, then 0 -> SW_ADDR stays 0 throughout.
REQ-036 A directed scenario SHALL cover: btn_in held high 10 cycles -> STAT_ADDR reads 1; a second read after the clearing edge reads 0; holding the button does not re-set pending.
REQ-037 A directed scenario SHALL cover: a debounced press lands on the same edge as a STAT_ADDR read -> that read returns 0 and the next read returns 1.
REQ-038 A directed scenario SHALL cover: LED=24'h0000FF, then reset_n pulsed low between edges -> led_out=0 immediately; writes to SW_ADDR or 32'hFFFFFC64 leave all state unchanged and read 0 where unmapped.

Source files
------------

// File: rtl/led_switch_io.sv
// LED / switch / button IO block on the memory-mapped IO bus.
//   - LED register: read/write, drives led_out directly.
//   - Switches: 2-flop synchronised, debounced by one shared counter,
//     readable as a 24-bit word.
//   - Button: 2-flop synchronised, debounced by its own counter; a debounced
//     press latches a pending flag that a status read clears.
//
// Bus semantics: io_read and io_write are single-cycle strobes with no
// back-pressure. A write takes effect on the rising edge where io_write is
// high and addr matches exactly. Read data is purely combinational from
// registered state, so a read in the same cycle as a write (or a status
// read-clear) returns the value held before that edge.
module led_switch_io #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter logic [31:0] LED_ADDR        = 32'hFFFFFC60,
  parameter logic [31:0] SW_ADDR         = 32'hFFFFFC70,
  parameter logic [31:0] STAT_ADDR       = 32'hFFFFFC74
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [23:0] io_rdata,
  input  logic [23:0] sw_in,
  input  logic        btn_in,
  output logic [23:0] led_out
);

  // One spare bit above the bits needed for DEBOUNCE_CYCLES-1, so the
  // terminal compare can never be missed by a wrap.
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [23:0]   led_q;
  logic [23:0]   sw_meta;
  logic [23:0]   sw_sync;
  logic [23:0]   sw_stable;
  logic [CW-1:0] sw_cnt;
  logic          btn_meta;
  logic          btn_sync;
  logic          btn_stable;
  logic [CW-1:0] btn_cnt;
  logic          pending;

  logic          led_wr;
  logic          stat_rd;
  logic          sw_differs;
  logic          sw_accept;
  logic          btn_differs;
  logic          btn_accept;
  logic          press_event;

  // Upper write-data byte has no destination in this block.
  logic          unused_wdata_hi;
  assign unused_wdata_hi = &{1'b0, wdata[31:24]};

  // Full 32-bit decode, qualified by the strobes.
  assign led_wr  = io_write && (addr == LED_ADDR);
  assign stat_rd = io_read  && (addr == STAT_ADDR);

  // A new value is accepted on the edge where the counter has already
  // reached DEBOUNCE_CYCLES-1 and the synced input still differs.
  assign sw_differs  = (sw_sync != sw_stable);
  assign sw_accept   = sw_differs && (sw_cnt == CNT_LAST);
  assign btn_differs = (btn_sync != btn_stable);
  assign btn_accept  = btn_differs && (btn_cnt == CNT_LAST);
  // Only a debounced 0->1 transition counts as a press.
  assign press_event = btn_accept && btn_sync;

  assign led_out = led_q;

  // LED register: loads low 24 bits of wdata on a decoded write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_q <= '0;
    end else if (led_wr) begin
      led_q <= wdata[23:0];
    end
  end

  // Two-flop synchronisers for the asynchronous board inputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sw_meta  <= sw_in;
      sw_sync  <= sw_meta;
      btn_meta <= btn_in;
      btn_sync <= btn_meta;
    end
  end

  // Switch debounce: any cycle back at the stable value restarts the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_stable <= '0;
      sw_cnt    <= '0;
    end else if (!sw_differs) begin
      sw_cnt <= '0;
    end else if (sw_accept) begin
      sw_stable <= sw_sync;
      sw_cnt    <= '0;
    end else begin
      sw_cnt <= sw_cnt + CW'(1);
    end
  end

  // Button debounce: same rule as the switches, independent counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_stable <= 1'b0;
      btn_cnt    <= '0;
    end else if (!btn_differs) begin
      btn_cnt <= '0;
    end else if (btn_accept) begin
      btn_stable <= btn_sync;
      btn_cnt    <= '0;
    end else begin
      btn_cnt <= btn_cnt + CW'(1);
    end
  end

  // Press-pending flag: a press on the same edge as a read-clear wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
    end else if (press_event) begin
      pending <= 1'b1;
    end else if (stat_rd) begin
      pending <= 1'b0;
    end
  end

  // Read mux from registered state; zero when idle or unmapped.
  always_comb begin
    io_rdata = '0;
    if (io_read) begin
      if (addr == LED_ADDR) begin
        io_rdata = led_q;
      end else if (addr == SW_ADDR) begin
        io_rdata = sw_stable;
      end else if (addr == STAT_ADDR) begin
        io_rdata = {23'b0, pending};
      end
    end
  end

endmodule

// File: tb/tb_led_switch_io.sv
// Self-checking bench for led_switch_io with a short debounce window.
module tb_led_switch_io;

  localparam int unsigned DB = 4;
  localparam logic [31:0] LED_A   = 32'hFFFFFC60;
  localparam logic [31:0] SW_A    = 32'hFFFFFC70;
  localparam logic [31:0] STAT_A  = 32'hFFFFFC74;
  localparam logic [31:0] HOLE_A  = 32'hFFFFFC64;

  logic        clock;
  logic        reset_n;
  logic        io_read;
  logic        io_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [23:0] io_rdata;
  logic [23:0] sw_in;
  logic        btn_in;
  logic [23:0] led_out;

  int total;
  int bad;

  led_switch_io #(
    .DEBOUNCE_CYCLES(DB),
    .LED_ADDR(LED_A),
    .SW_ADDR(SW_A),
    .STAT_ADDR(STAT_A)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .io_read(io_read),
    .io_write(io_write),
    .addr(addr),
    .wdata(wdata),
    .io_rdata(io_rdata),
    .sw_in(sw_in),
    .btn_in(btn_in),
    .led_out(led_out)
  );

  // Clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- behavioural reference model ----------------
  // Raw inputs reach the debouncer two edges after they are sampled; a
  // value is accepted on the DB-th consecutive edge on which the delayed
  // input differs from the accepted value.
  logic [23:0] m_led;
  logic [23:0] m_sw;
  logic        m_btn;
  logic        m_pend;
  int          sw_run;
  int          btn_run;
  logic [23:0] sw_line[$];
  logic        btn_line[$];

  task automatic model_reset();
    m_led   = '0;
    m_sw    = '0;
    m_btn   = 1'b0;
    m_pend  = 1'b0;
    sw_run  = 0;
    btn_run = 0;
    sw_line  = {24'h0, 24'h0};
    btn_line = {1'b0, 1'b0};
  endtask

  function automatic logic [23:0] model_rdata();
    if (!io_read) return 24'h0;
    if (addr == LED_A) return m_led;
    if (addr == SW_A) return m_sw;
    if (addr == STAT_A) return {23'b0, m_pend};
    return 24'h0;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    logic [23:0] sw_seen;
    logic        btn_seen;
    logic        press;
    sw_seen  = sw_line.pop_front();
    sw_line.push_back(sw_in);
    btn_seen = btn_line.pop_front();
    btn_line.push_back(btn_in);
    press = 1'b0;
    if (io_write && addr == LED_A) m_led = wdata[23:0];
    if (sw_seen == m_sw) sw_run = 0;
    else begin
      sw_run++;
      if (sw_run == int'(DB)) begin
        m_sw = sw_seen;
        sw_run = 0;
      end
    end
    if (btn_seen == m_btn) btn_run = 0;
    else begin
      btn_run++;
      if (btn_run == int'(DB)) begin
        m_btn = btn_seen;
        btn_run = 0;
        press = btn_seen;
      end
    end
    if (io_read && addr == STAT_A) m_pend = 1'b0;
    if (press) m_pend = 1'b1;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    io_read  = rd;
    io_write = wr;
    addr     = a;
    wdata    = wd;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [23:0] exp_rdata;
    logic [23:0] exp_led;
  } vec_t;

  vec_t vecs[11];

  // ---------------- main test ----------------
  initial begin
    logic [23:0] sw_pick;
    int          sw_hold;
    int          btn_hold;
    total = 0;
    bad   = 0;

    vecs[0]  = '{1'b0, 1'b1, LED_A,        32'hAB123456, 24'h000000, 24'h123456};
    vecs[1]  = '{1'b1, 1'b0, LED_A,        32'h00000000, 24'h123456, 24'h123456};
    vecs[2]  = '{1'b1, 1'b1, LED_A,        32'h11000077, 24'h123456, 24'h000077};
    vecs[3]  = '{1'b1, 1'b1, SW_A,         32'hFFFFFFFF, 24'h000000, 24'h000077};
    vecs[4]  = '{1'b0, 1'b1, STAT_A,       32'hFFFFFFFF, 24'h000000, 24'h000077};
    vecs[5]  = '{1'b1, 1'b1, HOLE_A,       32'hFFFFFFFF, 24'h000000, 24'h000077};
    vecs[6]  = '{1'b1, 1'b1, 32'h7FFFFC60, 32'h00FFFFFF, 24'h000000, 24'h000077};
    vecs[7]  = '{1'b1, 1'b0, STAT_A,       32'h00000000, 24'h000000, 24'h000077};
    vecs[8]  = '{1'b0, 1'b0, LED_A,        32'h00000000, 24'h000000, 24'h000077};
    vecs[9]  = '{1'b1, 1'b0, 32'h00000000, 32'h00000000, 24'h000000, 24'h000077};
    vecs[10] = '{1'b1, 1'b0, LED_A,        32'h00000000, 24'h000077, 24'h000077};

    reset_n = 1'b0;
    sw_in   = '0;
    btn_in  = 1'b0;
    bus(1'b1, 1'b0, LED_A, 32'h0);
    #3;
    check("reset_led_out", led_out, 24'h0);
    check("reset_rd_led", io_rdata, 24'h0);
    addr = STAT_A;
    #1;
    check("reset_rd_stat", io_rdata, 24'h0);
    #8;
    reset_n = 1'b1;

    // Register / decode vectors; the first one lands on the first edge after reset.
    for (int i = 0; i < 11; i++) begin
      bus(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd);
      #1;
      check($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
      tick();
      check($sformatf("vec%0d_led", i), led_out, vecs[i].exp_led);
    end

    // Held switch change appears on the 6th edge.
    bus(1'b1, 1'b0, SW_A, 32'h0);
    sw_in = 24'h00F00F;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("sw_hold_e%0d", k), io_rdata, (k < 6) ? 24'h0 : 24'h00F00F);
    end
    sw_in = 24'h0;
    repeat (8) tick();
    check("sw_back_to_zero", io_rdata, 24'h0);

    // Three-cycle glitch never reaches the stable value.
    sw_in = 24'hFFFFFF;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("glitch_on_e%0d", k), io_rdata, 24'h0);
    end
    sw_in = 24'h0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("glitch_off_e%0d", k), io_rdata, 24'h0);
    end

    // Button press sets pending once; read clears it.
    bus(1'b0, 1'b0, STAT_A, 32'h0);
    btn_in = 1'b1;
    repeat (10) tick();
    io_read = 1'b1;
    #1;
    check("btn_pending", io_rdata, 24'h1);
    tick();
    check("btn_after_clear", io_rdata, 24'h0);
    io_read = 1'b0;
    repeat (6) tick();
    io_read = 1'b1;
    #1;
    check("btn_held_no_reset", io_rdata, 24'h0);
    io_read = 1'b0;
    btn_in  = 1'b0;
    repeat (8) tick();
    io_read = 1'b1;
    #1;
    check("btn_release_no_set", io_rdata, 24'h0);
    tick();
    io_read = 1'b0;

    // Press acceptance on the same edge as a status read.
    btn_in = 1'b1;
    repeat (5) tick();
    io_read = 1'b1;
    #1;
    check("same_edge_read", io_rdata, 24'h0);
    tick();
    check("after_same_edge", io_rdata, 24'h1);
    tick();
    io_read = 1'b0;
    btn_in  = 1'b0;
    repeat (8) tick();

    // Asynchronous reset between edges, then writes to read-only / unmapped.
    bus(1'b0, 1'b1, LED_A, 32'h000000FF);
    tick();
    io_write = 1'b0;
    check("led_ff", led_out, 24'h0000FF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_led", led_out, 24'h0);
    bus(1'b1, 1'b0, LED_A, 32'h0);
    #1;
    check("async_reset_rd_led", io_rdata, 24'h0);
    reset_n = 1'b1;
    bus(1'b1, 1'b1, SW_A, 32'hFFFFFFFF);
    #1;
    check("wr_sw_rdata", io_rdata, 24'h0);
    tick();
    check("wr_sw_led", led_out, 24'h0);
    bus(1'b1, 1'b1, HOLE_A, 32'hFFFFFFFF);
    #1;
    check("wr_hole_rdata", io_rdata, 24'h0);
    tick();
    check("wr_hole_led", led_out, 24'h0);
    bus(1'b1, 1'b0, LED_A, 32'h0);
    #1;
    check("post_hole_rd_led", io_rdata, 24'h0);
    addr = STAT_A;
    #1;
    check("post_hole_rd_stat", io_rdata, 24'h0);

    // Reset mid-debounce discards the partial count.
    bus(1'b1, 1'b0, SW_A, 32'h0);
    sw_in = 24'h000ABC;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("mid_reset_e%0d", k), io_rdata, (k < 6) ? 24'h0 : 24'h000ABC);
    end

    // Randomised traffic against the reference model.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    model_reset();
    sw_hold  = 0;
    btn_hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (sw_hold == 0) begin
        case ($urandom_range(0, 3))
          0: sw_pick = 24'h0;
          1: sw_pick = 24'h00F00F;
          2: sw_pick = 24'($urandom);
          default: sw_pick = 24'hFFFFFF;
        endcase
        sw_in   = sw_pick;
        sw_hold = $urandom_range(1, 7);
      end
      sw_hold--;
      if (btn_hold == 0) begin
        btn_in   = 1'($urandom_range(0, 1));
        btn_hold = $urandom_range(1, 9);
      end
      btn_hold--;
      case ($urandom_range(0, 4))
        0: addr = LED_A;
        1: addr = SW_A;
        2: addr = STAT_A;
        3: addr = HOLE_A;
        default: addr = $urandom;
      endcase
      io_read  = 1'($urandom_range(0, 1));
      io_write = ($urandom_range(0, 3) == 0);
      wdata    = $urandom;
      #1;
      check("rand_rdata", io_rdata, model_rdata());
      model_edge();
      tick();
      check("rand_led", led_out, m_led);
      if ($urandom_range(0, 99) == 0) begin
        reset_n = 1'b0;
        #1;
        check("rand_reset_led", led_out, 24'h0);
        reset_n = 1'b1;
        model_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
